// File: rtl/hal_ram_pkg.sv
// hal_ram_pkg
//   Shared types and helpers for the HAL single-clock RAM family.
//   - ram_state_t   : init sequencer states (CLEAR sweep, READY for traffic)
//   - num_bytes     : byte-enable lane count for a word/lane width pair
//   - widths_legal  : word width is a non-zero multiple of the lane width and
//                     fits the merge helper
//   - latency_legal : supported read latency range
//   - byte_merge    : per-lane merge of a new word over an old word
package hal_ram_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } ram_state_t;

  // Upper bound on word width handled by byte_merge; callers zero-extend
  // into this width and truncate the result back down.
  localparam int unsigned MAX_DATA_WIDTH = 512;

  function automatic int unsigned num_bytes(input int unsigned data_width,
                                            input int unsigned byte_width);
    return data_width / byte_width;
  endfunction

  function automatic bit widths_legal(input int unsigned data_width,
                                      input int unsigned byte_width);
    return (byte_width != 0) && (data_width != 0) &&
           (data_width % byte_width == 0) && (data_width <= MAX_DATA_WIDTH);
  endfunction

  function automatic bit latency_legal(input int unsigned read_latency);
    return (read_latency >= 1) && (read_latency <= 4);
  endfunction

  // Bit b belongs to lane b/byte_width; enabled lanes take new_word.
  function automatic logic [MAX_DATA_WIDTH-1:0] byte_merge(
      input logic [MAX_DATA_WIDTH-1:0] old_word,
      input logic [MAX_DATA_WIDTH-1:0] new_word,
      input logic [MAX_DATA_WIDTH-1:0] byteen,
      input int unsigned               byte_width);
    logic [MAX_DATA_WIDTH-1:0] merged;
    merged = old_word;
    for (int unsigned b = 0; b < MAX_DATA_WIDTH; b++) begin
      if (byteen[b / byte_width]) begin
        merged[b] = new_word[b];
      end
    end
    return merged;
  endfunction

endpackage

// File: rtl/hal_sdp_ram_bypass_init_valid_pipe.sv
// hal_valid_delay_pipe
//   Delays a {valid, data} pair by DEPTH register stages. Each stage loads
//   data only when the incoming valid is set, so the last stage holds the
//   most recent valid word while valid is low. rst clears every stage.
//   DEPTH = 0 is a combinational pass-through.
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   in_valid/data   upstream pair
//   out_valid/data  delayed pair
module hal_valid_delay_pipe #(
  parameter int unsigned DEPTH = 1,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
);

  if (DEPTH == 0) begin : g_passthrough
    assign out_valid = in_valid;
    assign out_data  = in_data;
  end else begin : g_stages
    // chain[0] is the input, chain[s+1] is the output of stage s.
    logic [DEPTH:0]   chain_valid;
    logic [WIDTH-1:0] chain_data [DEPTH+1];

    logic [DEPTH-1:0] valid_q, valid_d;
    logic [WIDTH-1:0] data_q [DEPTH];
    logic [WIDTH-1:0] data_d [DEPTH];

    assign chain_valid = {valid_q, in_valid};

    always_comb begin
      chain_data[0] = in_data;
      for (int unsigned s = 0; s < DEPTH; s++) begin
        chain_data[s+1] = data_q[s];
      end
    end

    always_comb begin
      for (int unsigned s = 0; s < DEPTH; s++) begin
        valid_d[s] = chain_valid[s];
        data_d[s]  = chain_valid[s] ? chain_data[s] : data_q[s];
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        valid_q <= '0;
        for (int unsigned s = 0; s < DEPTH; s++) begin
          data_q[s] <= '0;
        end
      end else begin
        valid_q <= valid_d;
        for (int unsigned s = 0; s < DEPTH; s++) begin
          data_q[s] <= data_d[s];
        end
      end
    end

    assign out_valid = chain_valid[DEPTH];
    assign out_data  = chain_data[DEPTH];
  end

endmodule

// File: rtl/hal_sdp_ram_bypass_init.sv
// hal_sdp_ram_bypass_init
//   Single-clock simple dual-port RAM (one write port, one read port) with
//   byte-enable writes, READ_LATENCY-cycle reads qualified by valid_out,
//   optional same-cycle write-to-read bypass and a post-reset clear sweep.
// Ports:
//   clk, rst      single clock, synchronous active-high reset
//   init_done     high once the clear sweep has finished; requests are
//                 ignored while low
//   wren_in, writeaddr_in, byteen_in, data_in   write port
//   rden_in, readaddr_in                        read request
//   data_out, valid_out   read result READ_LATENCY cycles after rden_in;
//                         data_out holds its last value when valid_out=0
module hal_sdp_ram_bypass_init
  import hal_ram_pkg::*;
#(
  parameter int unsigned            DATA_WIDTH     = 64,
  parameter int unsigned            ADDR_WIDTH     = 9,
  parameter int unsigned            BYTE_WIDTH     = 8,
  parameter int unsigned            READ_LATENCY   = 2,
  parameter bit                     BYPASS         = 1'b1,
  parameter bit                     CLEAR_ON_RESET = 1'b1,
  parameter logic [DATA_WIDTH-1:0]  CLEAR_VALUE    = '0,
  parameter string                  DEVICE_FAMILY  = "",
  localparam int unsigned           NUM_BYTES      = num_bytes(DATA_WIDTH, BYTE_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  init_done,
  input  logic                  wren_in,
  input  logic [ADDR_WIDTH-1:0] writeaddr_in,
  input  logic [NUM_BYTES-1:0]  byteen_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  rden_in,
  input  logic [ADDR_WIDTH-1:0] readaddr_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out
);

  localparam int unsigned DEPTH      = 2 ** ADDR_WIDTH;
  localparam int unsigned CNT_WIDTH  = ADDR_WIDTH + 1;
  localparam int unsigned PIPE_DEPTH = READ_LATENCY - 1;

  if (!widths_legal(DATA_WIDTH, BYTE_WIDTH)) begin : g_bad_width
    $error("DATA_WIDTH must be a non-zero multiple of BYTE_WIDTH");
  end
  if (!latency_legal(READ_LATENCY)) begin : g_bad_latency
    $error("READ_LATENCY must be in 1..4");
  end

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  ram_state_t            state_q, state_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  init_done_q, init_done_d;

  // Single write port shared by the clear sweep and user writes.
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [NUM_BYTES-1:0]  mem_be;
  logic [DATA_WIDTH-1:0] mem_wdata;

  logic                  rd_fire;
  logic [DATA_WIDTH-1:0] rd_word;
  logic [DATA_WIDTH-1:0] rd_word_merged;
  logic                  rd_valid_q, rd_valid_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;

  // Sequencer and write-port mux.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mem_we    = 1'b0;
    mem_waddr = writeaddr_in;
    mem_be    = byteen_in;
    mem_wdata = data_in;

    case (state_q)
      CLEAR: begin
        if (CLEAR_ON_RESET) begin
          mem_we    = 1'b1;
          mem_waddr = cnt_q[ADDR_WIDTH-1:0];
          mem_be    = '1;
          mem_wdata = CLEAR_VALUE;
          cnt_d     = cnt_q + 1'b1;
          // The cycle that clears the last address hands over to READY.
          if (cnt_d == CNT_WIDTH'(DEPTH)) begin
            state_d = READY;
          end
        end else begin
          state_d = READY;
        end
      end
      READY: begin
        mem_we = wren_in;
      end
      default: begin
        state_d = CLEAR;
      end
    endcase

    if (rst) begin
      state_d = CLEAR;
      cnt_d   = '0;
      mem_we  = 1'b0;
    end

    // init_done is registered from the next state so it is high exactly
    // while the sequencer sits in READY.
    init_done_d = (state_d == READY);
  end

  // Memory array: no reset, lanes written individually.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int unsigned i = 0; i < NUM_BYTES; i++) begin
        if (mem_be[i]) begin
          mem[mem_waddr][i*BYTE_WIDTH +: BYTE_WIDTH] <= mem_wdata[i*BYTE_WIDTH +: BYTE_WIDTH];
        end
      end
    end
  end

  // Read port. The array read returns the pre-write word; with BYPASS the
  // lanes being written this cycle are patched in from the write data.
  always_comb begin
    rd_fire        = init_done_q && rden_in;
    rd_word        = mem[readaddr_in];
    rd_word_merged = rd_word;
    if (BYPASS && mem_we && (mem_waddr == readaddr_in)) begin
      rd_word_merged = DATA_WIDTH'(byte_merge(MAX_DATA_WIDTH'(rd_word),
                                              MAX_DATA_WIDTH'(mem_wdata),
                                              MAX_DATA_WIDTH'(mem_be),
                                              BYTE_WIDTH));
    end
    rd_valid_d = rd_fire;
    rd_data_d  = rd_fire ? rd_word_merged : rd_data_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= CLEAR;
      cnt_q       <= '0;
      init_done_q <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      init_done_q <= init_done_d;
      rd_valid_q  <= rd_valid_d;
      rd_data_q   <= rd_data_d;
    end
  end

  // First latency cycle is the output register above; the rest are here.
  hal_valid_delay_pipe #(
    .DEPTH (PIPE_DEPTH),
    .WIDTH (DATA_WIDTH)
  ) u_valid_pipe (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (rd_valid_q),
    .in_data   (rd_data_q),
    .out_valid (valid_out),
    .out_data  (data_out)
  );

  assign init_done = init_done_q;

endmodule

// File: tb/tb_hal_sdp_ram_bypass_init.sv
module tb_hal_sdp_ram_bypass_init;

  localparam int DW    = 32;
  localparam int AW    = 4;
  localparam int NB    = 4;
  localparam int LAT_A = 2;
  localparam int LAT_B = 4;
  localparam logic [DW-1:0] CLR = 32'h0000_A5A5;

  logic          clk = 1'b0;
  logic          rst;
  logic          wren;
  logic [AW-1:0] waddr;
  logic [NB-1:0] be;
  logic [DW-1:0] wdata;
  logic          rden;
  logic [AW-1:0] raddr;

  logic          init_a, init_b, valid_a, valid_b;
  logic [DW-1:0] dout_a, dout_b;

  always #5 clk = ~clk;

  // dut_a: latency 2, bypass on.  dut_b: latency 4, read-first.
  hal_sdp_ram_bypass_init #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BYTE_WIDTH(8), .READ_LATENCY(LAT_A),
    .BYPASS(1'b1), .CLEAR_ON_RESET(1'b1), .CLEAR_VALUE(CLR), .DEVICE_FAMILY("")
  ) dut_a (
    .clk(clk), .rst(rst), .init_done(init_a),
    .wren_in(wren), .writeaddr_in(waddr), .byteen_in(be), .data_in(wdata),
    .rden_in(rden), .readaddr_in(raddr), .data_out(dout_a), .valid_out(valid_a)
  );

  hal_sdp_ram_bypass_init #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BYTE_WIDTH(8), .READ_LATENCY(LAT_B),
    .BYPASS(1'b0), .CLEAR_ON_RESET(1'b1), .CLEAR_VALUE(CLR), .DEVICE_FAMILY("")
  ) dut_b (
    .clk(clk), .rst(rst), .init_done(init_b),
    .wren_in(wren), .writeaddr_in(waddr), .byteen_in(be), .data_in(wdata),
    .rden_in(rden), .readaddr_in(raddr), .data_out(dout_b), .valid_out(valid_b)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;
  bit mon_en   = 1'b0;

  typedef struct {
    int            due;
    logic [DW-1:0] data;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h want %h", nm, cyc, act, exp);
    end
  endtask

  task automatic mon(input string nm, input logic vld, input logic [DW-1:0] dout,
                     input bit have, input exp_t e, output bit pop);
    bit exp_v;
    exp_v = have && (e.due == cyc);
    n_checks++;
    if (vld !== exp_v) begin
      n_fail++;
      $display("FAIL %s valid_out at cycle %0d: got %b want %b", nm, cyc, vld, exp_v);
    end
    if (exp_v && vld === 1'b1) begin
      n_checks++;
      if (dout !== e.data) begin
        n_fail++;
        $display("FAIL %s data_out at cycle %0d: got %h want %h", nm, cyc, dout, e.data);
      end
    end
    pop = exp_v;
  endtask

  // Monitor: every cycle, valid_out must be high exactly when a queued read
  // is due, and the data must match that entry.
  always @(negedge clk) begin
    exp_t ea, eb;
    bit   pa, pb;
    if (mon_en) begin
      ea = (q_a.size() > 0) ? q_a[0] : '{due: -1, data: '0};
      eb = (q_b.size() > 0) ? q_b[0] : '{due: -1, data: '0};
      mon("dut_a", valid_a, dout_a, q_a.size() > 0, ea, pa);
      mon("dut_b", valid_b, dout_b, q_b.size() > 0, eb, pb);
      if (pa) void'(q_a.pop_front());
      if (pb) void'(q_b.pop_front());
    end
  end

  // One cycle of stimulus; expectations are queued only for reads that
  // should produce a result.
  task automatic step(input bit we, input logic [AW-1:0] wa, input logic [NB-1:0] b,
                      input logic [DW-1:0] wd, input bit re, input logic [AW-1:0] ra,
                      input bit exp_rd, input logic [DW-1:0] ea, input logic [DW-1:0] eb);
    wren = we; waddr = wa; be = b; wdata = wd;
    rden = re; raddr = ra;
    if (re && exp_rd) begin
      q_a.push_back('{due: cyc + LAT_A, data: ea});
      q_b.push_back('{due: cyc + LAT_B, data: eb});
    end
    @(posedge clk); #1;
    wren = 1'b0; rden = 1'b0;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [NB-1:0] b, input logic [DW-1:0] d);
    step(1'b1, a, b, d, 1'b0, '0, 1'b0, '0, '0);
  endtask

  task automatic rd(input logic [AW-1:0] a, input logic [DW-1:0] ea, input logic [DW-1:0] eb);
    step(1'b0, '0, '0, '0, 1'b1, a, 1'b1, ea, eb);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  // Reads whose result would land after the reset edge are dropped.
  task automatic assert_rst();
    rst = 1'b1;
    while (q_a.size() > 0 && q_a[$].due > cyc) void'(q_a.pop_back());
    while (q_b.size() > 0 && q_b[$].due > cyc) void'(q_b.pop_back());
    @(posedge clk); #1;
  endtask

  // Release reset: init_done low for 16 cycles, high on the 17th.
  task automatic release_and_check_sweep(input bit poke);
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      chk("init_a_low", {31'b0, init_a}, 32'd0);
      chk("init_b_low", {31'b0, init_b}, 32'd0);
      if (poke && i == 4) step(1'b1, 4'd2, 4'hF, 32'h55, 1'b1, 4'd2, 1'b0, '0, '0);
      else idle(1);
    end
    chk("init_a_high", {31'b0, init_a}, 32'd1);
    chk("init_b_high", {31'b0, init_b}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; wren = 1'b0; waddr = '0; be = '0; wdata = '0; rden = 1'b0; raddr = '0;
    @(posedge clk); #1;
    mon_en = 1'b1;
    @(posedge clk); #1;
    chk("rst_init_a",  {31'b0, init_a},  32'd0);
    chk("rst_init_b",  {31'b0, init_b},  32'd0);
    chk("rst_valid_a", {31'b0, valid_a}, 32'd0);
    chk("rst_valid_b", {31'b0, valid_b}, 32'd0);
    chk("rst_dout_a",  dout_a, 32'd0);
    chk("rst_dout_b",  dout_b, 32'd0);

    // Sweep, with a write+read to addr 2 issued mid-sweep (must be ignored).
    release_and_check_sweep(1'b1);

    for (int a = 0; a < 16; a++) rd(AW'(a), CLR, CLR);
    idle(6);

    // Byte-enable merge.
    wr(4'd3, 4'hF, 32'h1122_3344);
    wr(4'd3, 4'h5, 32'hFFFF_FFFF);
    rd(4'd3, 32'h11FF_33FF, 32'h11FF_33FF);
    idle(6);
    chk("hold_a", dout_a, 32'h11FF_33FF);
    chk("hold_b", dout_b, 32'h11FF_33FF);

    // Same-cycle collision: bypass vs read-first.
    wr(4'd7, 4'hF, 32'h0102_0304);
    step(1'b1, 4'd7, 4'h3, 32'hDEAD_BEEF, 1'b1, 4'd7, 1'b1, 32'h0102_BEEF, 32'h0102_0304);
    rd(4'd7, 32'h0102_BEEF, 32'h0102_BEEF);

    // Writes after a read is issued do not reach it.
    rd(4'd3, 32'h11FF_33FF, 32'h11FF_33FF);
    wr(4'd3, 4'hF, 32'h0000_0000);
    wr(4'd3, 4'hF, 32'h1234_5678);
    wr(4'd3, 4'hF, 32'h0000_0009);
    rd(4'd3, 32'h0000_0009, 32'h0000_0009);

    // All-zero byte enable is a no-op.
    wr(4'd5, 4'h0, 32'hFFFF_FFFF);
    rd(4'd5, CLR, CLR);
    idle(6);

    // Back-to-back reads, no bubbles.
    for (int a = 0; a < 8; a++) wr(AW'(a), 4'hF, 32'h1000_0000 + 32'(a) * 32'h0101);
    for (int a = 0; a < 8; a++) rd(AW'(a), 32'h1000_0000 + 32'(a) * 32'h0101,
                                   32'h1000_0000 + 32'(a) * 32'h0101);
    idle(6);

    // Reset with reads in flight.
    rd(4'd8, CLR, CLR);
    rd(4'd9, CLR, CLR);
    rd(4'd10, CLR, CLR);
    assert_rst();
    chk("flush_valid_a", {31'b0, valid_a}, 32'd0);
    chk("flush_valid_b", {31'b0, valid_b}, 32'd0);
    chk("flush_dout_a", dout_a, 32'd0);
    chk("flush_dout_b", dout_b, 32'd0);

    // Reset again five cycles into the sweep; sweep restarts from 0.
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("partial_init_a", {31'b0, init_a}, 32'd0);
      idle(1);
    end
    assert_rst();
    release_and_check_sweep(1'b0);

    rd(4'd0, CLR, CLR);
    rd(4'd3, CLR, CLR);
    rd(4'd7, CLR, CLR);
    idle(8);
    chk("drain_a", 32'(q_a.size()), 32'd0);
    chk("drain_b", 32'(q_b.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
